// File: rtl/derive_size_pkg.sv
// Shared types and helpers for the derive_size actor family.
// Holds tag sizing, saturating subtract and saturation mode constants.
package derive_size_pkg;

  typedef enum logic {
    SAT_WRAP  = 1'b0,
    SAT_CLAMP = 1'b1
  } sat_mode_e;

  function automatic int tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] sub_sat(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          w,
    input bit          clamp
  );
    logic [31:0] mask;
    logic [31:0] d;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    d = (a - b) & mask;
    if (clamp && (a < b)) d = '0;
    return d;
  endfunction

endpackage

// File: rtl/derive_size_rr_if.sv
// FIFO bank handshake bundles: a source bank read by an actor
// and a sink bank written by an actor.
interface read_interface #(
  parameter int FLUX  = 2,
  parameter int WIDTH = 8
);
  logic [FLUX-1:0]  empty;
  logic [FLUX-1:0]  read;
  logic [WIDTH-1:0] dout;

  modport actor (input empty, input dout, output read);
  modport fifo  (output empty, output dout, input read);
endinterface

interface write_interface #(
  parameter int FLUX  = 2,
  parameter int WIDTH = 8
);
  logic [FLUX-1:0]  full;
  logic             write;
  logic [WIDTH-1:0] din;

  modport actor (input full, output write, output din);
  modport fifo  (output full, input write, input din);
endinterface

// File: rtl/derive_size_rr_arbiter.sv
// Round-robin search over N requesters starting at ptr,
// wrapping N-1 -> 0; the first requester found wins.
module rr_arbiter
  import derive_size_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = tag_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          gnt_valid,
  output logic [PW-1:0] gnt_idx
);

  logic [N-1:0]  rot;
  logic [PW-1:0] off;
  logic [PW:0]   sum;

  always_comb begin
    // rotate so that bit 0 is the requester at ptr
    rot = N'({req, req} >> ptr);
    gnt_valid = 1'b0;
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_valid = 1'b1;
        off = PW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PW+1)'(N)) begin
      gnt_idx = PW'(sum - (PW+1)'(N));
    end else begin
      gnt_idx = PW'(sum);
    end
  end

endmodule

// File: rtl/derive_size_rr.sv
// Multi-flux actor: round-robin picks a flux, subtracts DIFF from
// its payload and emits a tagged token through a 1-deep register.
module derive_size_rr
  import derive_size_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 7,
  parameter int DIFF       = 7,
  parameter int SATURATE   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  read_interface.actor    read_port_ext_size,
  write_interface.actor   write_port_real_size,
  output logic [FLUX-1:0] underflow
);

  localparam int TAG_WIDTH = tag_width(FLUX);
  localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;
  localparam bit CLAMP     = (SATURATE == int'(SAT_CLAMP));

  logic [FLUX-1:0]       req;
  logic                  gnt_valid;
  logic [TAG_WIDTH-1:0]  gnt_idx;
  logic [TAG_WIDTH-1:0]  rr_ptr;
  logic [TAG_WIDTH-1:0]  next_ptr;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_valid;
  logic [WIDTH-1:0]      din_q;
  logic                  fire;
  logic                  accept;
  logic [FLUX-1:0]       read_vec;
  logic [DATA_WIDTH-1:0] payload;
  logic [DATA_WIDTH-1:0] result;
  logic                  under;
  logic                  tag_unused;

  assign req = ~read_port_ext_size.empty
             & ~write_port_real_size.full;

  rr_arbiter #(
    .N (FLUX)
  ) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign out_tag = din_q[WIDTH-1 -: TAG_WIDTH];
  assign fire    = out_valid
                 & ~write_port_real_size.full[out_tag];
  // rst_n gate keeps read low while reset is held
  assign accept  = rst_n & gnt_valid & (~out_valid | fire);

  always_comb begin
    read_vec = '0;
    for (int i = 0; i < FLUX; i++) begin
      read_vec[i] = accept && (gnt_idx == TAG_WIDTH'(i));
    end
  end

  assign read_port_ext_size.read = read_vec;

  assign payload    = read_port_ext_size.dout[DATA_WIDTH-1:0];
  assign tag_unused = ^read_port_ext_size.dout[WIDTH-1:DATA_WIDTH];
  assign under      = payload < DATA_WIDTH'(DIFF);
  assign result     = DATA_WIDTH'(sub_sat(32'(payload), 32'(DIFF),
                                          DATA_WIDTH, CLAMP));

  assign next_ptr = (gnt_idx == TAG_WIDTH'(FLUX - 1))
                  ? '0 : gnt_idx + TAG_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      din_q     <= '0;
      rr_ptr    <= '0;
      underflow <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        din_q     <= {gnt_idx, result};
        rr_ptr    <= next_ptr;
        if (under) underflow[gnt_idx] <= 1'b1;
      end else if (fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign write_port_real_size.write = fire;
  assign write_port_real_size.din   = din_q;

endmodule

// File: tb/tb_derive_size_rr.sv
// Scoreboard bench: FIFO bank models feed two actor instances,
// monitors pop hand-computed tokens whenever a write is presented.
module tb_derive_size_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wcnt1 = 0;
  int wcnt2 = 0;

  read_interface  #(.FLUX(2), .WIDTH(8)) rd1 ();
  write_interface #(.FLUX(2), .WIDTH(8)) wr1 ();
  logic [1:0] uf1;
  read_interface  #(.FLUX(3), .WIDTH(9)) rd2 ();
  write_interface #(.FLUX(3), .WIDTH(9)) wr2 ();
  logic [2:0] uf2;

  derive_size_rr #(
    .FLUX(2), .DATA_WIDTH(7), .DIFF(7), .SATURATE(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .read_port_ext_size(rd1),
    .write_port_real_size(wr1),
    .underflow(uf1)
  );

  derive_size_rr #(
    .FLUX(3), .DATA_WIDTH(7), .DIFF(7), .SATURATE(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .read_port_ext_size(rd2),
    .write_port_real_size(wr2),
    .underflow(uf2)
  );

  logic [7:0] m1 [2][32];
  int rp1 [2] = '{0, 0};
  int wp1 [2] = '{0, 0};
  logic [8:0] m2 [3][32];
  int rp2 [3] = '{0, 0, 0};
  int wp2 [3] = '{0, 0, 0};
  logic [7:0] exp1 [$];
  logic [8:0] exp2 [$];

  always_comb begin
    rd1.empty = '0;
    rd1.dout = '0;
    for (int i = 0; i < 2; i++) begin
      rd1.empty[i] = (rp1[i] == wp1[i]);
      if (rd1.read[i]) rd1.dout = m1[i][rp1[i]];
    end
  end

  always_comb begin
    rd2.empty = '0;
    rd2.dout = '0;
    for (int i = 0; i < 3; i++) begin
      rd2.empty[i] = (rp2[i] == wp2[i]);
      if (rd2.read[i]) rd2.dout = m2[i][rp2[i]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (rd1.read[i]) rp1[i] <= rp1[i] + 1;
    for (int i = 0; i < 3; i++)
      if (rd2.read[i]) rp2[i] <= rp2[i] + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic push1(input int f, input logic [7:0] w);
    m1[f][wp1[f]] = w;
    wp1[f] = wp1[f] + 1;
  endtask

  task automatic push2(input int f, input logic [8:0] w);
    m2[f][wp2[f]] = w;
    wp2[f] = wp2[f] + 1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wr1.write) begin
      if (exp1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_extra_write got=%0h exp=none", wr1.din);
      end else begin
        logic [7:0] e;
        e = exp1.pop_front();
        chk("dut1_din", 32'(wr1.din), 32'(e));
      end
      wcnt1 <= wcnt1 + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && wr2.write) begin
      if (exp2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut2_extra_write got=%0h exp=none", wr2.din);
      end else begin
        logic [8:0] e;
        e = exp2.pop_front();
        chk("dut2_din", 32'(wr2.din), 32'(e));
      end
      wcnt2 <= wcnt2 + 1;
    end
  end

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    wr1.full = '0;
    wr2.full = '0;
    rst_n = 1'b0;
    // reset state, with a token already waiting (tag bit is garbage)
    push1(0, 8'h94);
    exp1.push_back(8'd13);
    step(2);
    chk("rst_read", 32'(rd1.read), 32'd0);
    chk("rst_write", 32'(wr1.write), 32'd0);
    chk("rst_din", 32'(wr1.din), 32'd0);
    chk("rst_uf", 32'(uf1), 32'd0);
    chk("rst_read2", 32'(rd2.read), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_read", 32'(rd1.read), 32'd1);
    @(negedge clk);
    chk("t1_write", 32'(wr1.write), 32'd1);
    step(2);

    // alternating grants, rr_ptr is 1 after the first grant
    for (int k = 0; k < 4; k++) begin
      push1(0, 8'(10 + k));
      push1(1, 8'(30 + k));
    end
    exp1.push_back(8'd151); exp1.push_back(8'd3);
    exp1.push_back(8'd152); exp1.push_back(8'd4);
    exp1.push_back(8'd153); exp1.push_back(8'd5);
    exp1.push_back(8'd154); exp1.push_back(8'd6);
    w = wcnt1;
    step(9);
    chk("t2_writes", 32'(wcnt1 - w), 32'd8);
    chk("t2_drained", 32'(exp1.size()), 32'd0);

    // stall on full[0] while holding {0,43}
    push1(0, 8'd50);
    exp1.push_back(8'd43);
    step(1);
    wr1.full[0] = 1'b1;
    push1(1, 8'd60);
    exp1.push_back(8'd181);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_hold_write", 32'(wr1.write), 32'd0);
      chk("t3_hold_read", 32'(rd1.read), 32'd0);
      chk("t3_hold_din", 32'(wr1.din), 32'd43);
    end
    @(posedge clk);
    #1;
    wr1.full[0] = 1'b0;
    @(negedge clk);
    chk("t3_fire", 32'(wr1.write), 32'd1);
    chk("t3_gnt1", 32'(rd1.read), 32'd2);
    step(2);

    // wrapping underflow
    chk("t4_uf_before", 32'(uf1), 32'd0);
    push1(1, 8'd3);
    exp1.push_back(8'd252);
    step(1);
    chk("t4_uf_after", 32'(uf1), 32'd2);
    step(2);

    // reset while a token is held
    push1(0, 8'd40);
    step(1);
    wr1.full[0] = 1'b1;
    step(1);
    chk("t5_hold_din", 32'(wr1.din), 32'd33);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_write", 32'(wr1.write), 32'd0);
    chk("t5_rst_din", 32'(wr1.din), 32'd0);
    chk("t5_rst_uf", 32'(uf1), 32'd0);
    wr1.full[0] = 1'b0;
    push1(0, 8'd100);
    push1(1, 8'h88);
    exp1.push_back(8'd93);
    exp1.push_back(8'd129);
    #1;
    chk("t5_rst_read", 32'(rd1.read), 32'd0);
    step(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_first_gnt", 32'(rd1.read), 32'd1);
    step(3);
    chk("t5_uf_clean", 32'(uf1), 32'd0);

    // FLUX=3 clamp, only flux2 eligible
    push2(2, 9'h183);
    push2(2, {2'b01, 7'd9});
    push2(2, {2'b00, 7'd20});
    push2(2, {2'b10, 7'd7});
    exp2.push_back(9'd256);
    exp2.push_back(9'd258);
    exp2.push_back(9'd269);
    exp2.push_back(9'd256);
    w = wcnt2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_gnt2", 32'(rd2.read), 32'd4);
    end
    step(2);
    chk("t6_writes", 32'(wcnt2 - w), 32'd4);
    chk("t6_uf", 32'(uf2), 32'd4);

    chk("end_exp1", 32'(exp1.size()), 32'd0);
    chk("end_exp2", 32'(exp2.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/derive_size_rr.md
DERIVE_SIZE_RR -- requirements
Module: derive_size_rr

Interface
REQ-001 SHALL have parameter FLUX, default 2, number of independent data fluxes (channels), legal range 1..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 7, width of the payload field.
REQ-003 SHALL have parameter DIFF, default 7, unsigned constant subtracted from each payload; DIFF < 2**DATA_WIDTH.
REQ-004 SHALL have parameter SATURATE, default 0: 0 = modulo wrap on underflow, 1 = clamp result to 0.
REQ-005 SHALL derive TAG_WIDTH = max(1, $clog2(FLUX)) and WIDTH = DATA_WIDTH+TAG_WIDTH.
REQ-006 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-007 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-008 Port: read_port_ext_size  read_interface.actor  empty[FLUX] in, read[FLUX] out, dout[WIDTH] in  source FIFO bank.
REQ-009 Port: write_port_real_size  write_interface.actor  full[FLUX] in, write out, din[WIDTH] out  sink FIFO bank.
REQ-010 Port: underflow  output  FLUX  sticky per-flux flag, set when payload < DIFF.

Function
REQ-011 Input payload SHALL be dout[DATA_WIDTH-1:0]; dout tag bits SHALL be ignored.
REQ-012 Flux i SHALL be eligible when empty[i]==0 and full[i]==0.
REQ-013 Arbitration SHALL be round-robin: search starts at rr_ptr, wraps FLUX-1 -> 0; first eligible flux is granted.
REQ-014 On an accepted grant g, rr_ptr SHALL become (g+1) mod FLUX; otherwise rr_ptr SHALL hold.
REQ-015 Accept condition: grant exists AND (out_valid==0 OR output fires this cycle).
REQ-016 read[g] SHALL be 1 combinationally only in an accept cycle; all other read bits 0; at most one read bit high per cycle.
REQ-017 On accept, output register SHALL load din = {g, result} and set out_valid=1 on the next edge: latency exactly 1 cycle, full throughput of 1 token/cycle.
REQ-018 result SHALL be (payload - DIFF) mod 2**DATA_WIDTH when SATURATE=0; 0 when SATURATE=1 and payload < DIFF.
REQ-019 When payload < DIFF on accept, underflow[g] SHALL set on the same edge and stay set until reset.
REQ-020 write SHALL equal out_valid AND full[out_tag]==0; output fires when write==1.
REQ-021 If output fires with no new accept, out_valid SHALL clear; din SHALL hold its last value.
REQ-022 If full[out_tag] asserts while out_valid==1, the register SHALL hold din stable and stall further accepts (head-of-line blocking across fluxes is intended).
REQ-023 Simultaneous fire and accept in one cycle SHALL replace the register contents without a bubble.
REQ-024 With FLUX==1, tag field SHALL be 1 bit, constant 0.
REQ-025 No output SHALL carry X in any cycle after reset release.

Reset
REQ-026 While rst_n==0: out_valid=0, write=0, read=all 0, din=0, rr_ptr=0, underflow=all 0.
REQ-027 Reset asserted mid-operation SHALL discard any held token immediately (asynchronously), without a write.
REQ-028 First accept SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-029 Package derive_size_pkg SHALL hold the tag-width function, the saturating-subtract function and SATURATE mode constants.
REQ-030 Round-robin search SHALL be sub-module rr_arbiter (parameter N; inputs req[N], ptr; outputs gnt_valid, gnt_idx), reusable by other multi-flux actors.
REQ-031 Output register, rr_ptr and underflow flags SHALL reside in derive_size_rr.

Verification
REQ-032 FLUX=2, DIFF=7: flux0 payload 20, flux1 empty -> read[0]=1 cycle N, write=1 with din={0,13} cycle N+1.
REQ-033 Both fluxes non-empty, sinks ready, 4 tokens each -> grants alternate 0,1,0,1..., one write per cycle, no bubbles.
REQ-034 full[0]=1 while holding {0,x}, flux1 ready -> din stable, read all 0 until full[0]=0, then write fires and flux1 granted same cycle.
REQ-035 payload 3, DIFF 7: SATURATE=0 -> result 124, underflow[g]=1; SATURATE=1 -> result 0, underflow[g]=1.
REQ-036 rst_n pulsed low while out_valid=1 -> write drops immediately, no write of held token, rr_ptr=0, first post-reset grant is flux0.
REQ-037 FLUX=3, only flux2 eligible repeatedly -> every cycle grants 2, rr_ptr stays 0 after each wrap, throughput 1/cycle.
